// File: rtl/sa_result_drain_if.sv
// sa_result_drain_if: groups the core-side capture signals and the serialised
// result stream of the systolic-array result drain.
//   routport   : per-row result words from the array core (ROWS x DW)
//   rvalidport : per-row result-valid bits from the array core
//   outread    : one-cycle capture acknowledge back to the core
//   out_data   : serialised result word
//   out_row    : row index of out_data
//   out_last   : final word of the current frame
//   out_valid  : stream valid
//   out_ready  : stream ready from downstream
// Modport master is the drain side; modport slave is the core/writeback side.
interface sa_result_drain_if #(
  parameter int ROWS = 8,
  parameter int DW   = 32
);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic [ROWS-1:0][DW-1:0] routport;
  logic [ROWS-1:0]         rvalidport;
  logic                    outread;
  logic [DW-1:0]           out_data;
  logic [RW-1:0]           out_row;
  logic                    out_last;
  logic                    out_valid;
  logic                    out_ready;

  modport master (
    input  routport, rvalidport, out_ready,
    output outread, out_data, out_row, out_last, out_valid
  );

  modport slave (
    output routport, rvalidport, out_ready,
    input  outread, out_data, out_row, out_last, out_valid
  );
endinterface

// File: rtl/sa_result_drain.sv
// sa_result_drain: snapshots every valid row of the array core's result bus
// in a single cycle, acknowledges the capture with a one-cycle outread pulse,
// then emits the captured rows in ascending row order on a valid/ready stream.
//
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : sa_result_drain_if.master (core capture + result stream)
//   frame_cnt, word_cnt : 16-bit wrapping statistics, present only when the
//                         macro SA_DRAIN_STATS_EN is defined
//
// State table:
//   IDLE  | waiting for any rvalidport bit; captures on that edge
//   DRAIN | emitting captured rows, lowest remaining row first
//   GAP   | one-cycle cooldown; rvalidport ignored so stale valids are dropped
module sa_result_drain #(
  parameter int ROWS = 8,
  parameter int DW   = 32
) (
  input  logic               clk,
  input  logic               rst,
  sa_result_drain_if.master  bus
`ifdef SA_DRAIN_STATS_EN
  ,
  output logic [15:0]        frame_cnt,
  output logic [15:0]        word_cnt
`endif
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [ROWS-1:0] MASK_ONE = ROWS'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [ROWS-1:0][DW-1:0] snap;
  logic [ROWS-1:0]         mask;
  logic                    outread_q;
  logic [RW-1:0]           cur_row;
  logic                    one_left;
  logic                    capture;
  logic                    draining;
  logic                    hs;

  // Lowest set mask bit selects the row on the stream.
  always_comb begin
    cur_row = '0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (mask[i]) cur_row = RW'(i);
    end
  end

  // Exactly one bit set: non-zero and clearing the lowest bit leaves nothing.
  assign one_left = (mask != '0) && ((mask & (mask - MASK_ONE)) == '0);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    draining  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.rvalidport != '0) begin
          capture   = 1'b1;
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        draining = 1'b1;
        if (bus.out_ready && one_left) state_nxt = GAP;
      end
      GAP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign hs = draining && bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      snap      <= '0;
      mask      <= '0;
      outread_q <= 1'b0;
    end else begin
      outread_q <= capture;
      if (capture) begin
        snap <= bus.routport;
        mask <= bus.rvalidport;
      end else if (hs) begin
        mask <= mask & ~(MASK_ONE << cur_row);
      end
    end
  end

  // Stream outputs are gated by DRAIN so they read zero outside a frame.
  assign bus.outread   = outread_q;
  assign bus.out_valid = draining;
  assign bus.out_row   = draining ? cur_row : '0;
  assign bus.out_data  = draining ? snap[cur_row] : '0;
  assign bus.out_last  = draining && one_left;

`ifdef SA_DRAIN_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= '0;
      word_cnt  <= '0;
    end else if (hs) begin
      word_cnt <= word_cnt + 16'd1;
      if (one_left) frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sa_result_drain.sv
module tb_sa_result_drain;
  localparam int ROWS = 8;
  localparam int DW   = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sa_result_drain_if #(.ROWS(ROWS), .DW(DW)) bus ();

`ifdef SA_DRAIN_STATS_EN
  logic [15:0] frame_cnt;
  logic [15:0] word_cnt;
`endif

  sa_result_drain #(.ROWS(ROWS), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef SA_DRAIN_STATS_EN
    ,
    .frame_cnt (frame_cnt),
    .word_cnt  (word_cnt)
`endif
  );

  typedef struct {
    logic [7:0]  valid;
    logic [7:0]  rdy_pat;
    logic [31:0] base;
    int          hold;
    int          exp_words;
    logic [2:0]  exp_last_row;
  } vec_t;

  vec_t vecs[6];
  vec_t v;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   hold_left = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance one cycle; rvalidport is held for hold_left more edges, and
  // routport is scrambled so a non-frozen snapshot would show up.
  task automatic tick();
    if (hold_left == 0) bus.rvalidport = '0;
    else hold_left--;
    for (int i = 0; i < ROWS; i++) bus.routport[i] = 32'hDEAD_0000 + 32'(i);
    step();
  endtask

  task automatic run_frame(input vec_t fv, input int idx);
    logic [7:0] rem;
    logic [2:0] er;
    logic [2:0] last_row;
    int nwords;
    int k;
    for (int i = 0; i < ROWS; i++) bus.routport[i] = fv.base + 32'(i);
    bus.rvalidport = fv.valid;
    bus.out_ready  = fv.rdy_pat[0];
    hold_left      = fv.hold;
    step();
    chk($sformatf("v%0d_outread_first", idx), 32'(bus.outread), 32'd1);
    chk($sformatf("v%0d_valid_first", idx), 32'(bus.out_valid), 32'd1);
    rem = fv.valid;
    nwords = 0;
    k = 0;
    last_row = '0;
    while (bus.out_valid && k < 64) begin
      er = '0;
      for (int i = ROWS - 1; i >= 0; i--) if (rem[i]) er = 3'(i);
      chk($sformatf("v%0d_k%0d_row", idx, k), 32'(bus.out_row), 32'(er));
      chk($sformatf("v%0d_k%0d_data", idx, k), bus.out_data, fv.base + 32'(er));
      chk($sformatf("v%0d_k%0d_last", idx, k), 32'(bus.out_last),
          32'((rem & (rem - 8'd1)) == 8'd0));
      if (k > 0) chk($sformatf("v%0d_k%0d_outread", idx, k), 32'(bus.outread), 32'd0);
      bus.out_ready = fv.rdy_pat[k % 8];
      if (bus.out_ready) begin
        rem[er]  = 1'b0;
        nwords++;
        last_row = er;
      end
      tick();
      k++;
    end
    chk($sformatf("v%0d_drain_timeout", idx), 32'(k < 64), 32'd1);
    chk($sformatf("v%0d_words", idx), 32'(nwords), 32'(fv.exp_words));
    chk($sformatf("v%0d_last_row", idx), 32'(last_row), 32'(fv.exp_last_row));
    chk($sformatf("v%0d_gap_outread", idx), 32'(bus.outread), 32'd0);
    tick();
    chk($sformatf("v%0d_idle_valid", idx), 32'(bus.out_valid), 32'd0);
    chk($sformatf("v%0d_idle_outread", idx), 32'(bus.outread), 32'd0);
    tick();
    chk($sformatf("v%0d_nostale_valid", idx), 32'(bus.out_valid), 32'd0);
    chk($sformatf("v%0d_nostale_outread", idx), 32'(bus.outread), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    //          valid  rdy_pat       base           hold words last
    vecs[0] = '{8'hFF, 8'hFF,        32'd100,       0,   8,    3'd7}; // full frame
    vecs[1] = '{8'hA4, 8'hFF,        32'h0000_0200, 0,   3,    3'd7}; // sparse 2,5,7
    vecs[2] = '{8'hFF, 8'b1001_1001, 32'd100,       0,   8,    3'd7}; // backpressure
    vecs[3] = '{8'hFF, 8'hFF,        32'hFFFF_FFF0, 2,   8,    3'd7}; // stale in DRAIN
    vecs[4] = '{8'h01, 8'hFF,        32'h5000_0000, 2,   1,    3'd0}; // stale in GAP
    vecs[5] = '{8'h5A, 8'b0110_0110, 32'hA5A5_0000, 1,   4,    3'd6}; // rows 1,3,4,6

    rst = 1'b1;
    bus.rvalidport = '0;
    bus.out_ready  = 1'b0;
    for (int i = 0; i < ROWS; i++) bus.routport[i] = '0;
    step();
    step();
    chk("rst_valid",   32'(bus.out_valid), 32'd0);
    chk("rst_outread", 32'(bus.outread),   32'd0);
    chk("rst_last",    32'(bus.out_last),  32'd0);
    chk("rst_data",    bus.out_data,       32'd0);
    chk("rst_row",     32'(bus.out_row),   32'd0);
`ifdef SA_DRAIN_STATS_EN
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("rst_word_cnt",  32'(word_cnt),  32'd0);
`endif
    rst = 1'b0;
    step();
    chk("post_rst_valid", 32'(bus.out_valid), 32'd0);

    for (int n = 0; n < 6; n++) run_frame(vecs[n], n);

    // Reset after three of eight words have been accepted.
    for (int i = 0; i < ROWS; i++) bus.routport[i] = 32'h100 + 32'(i);
    bus.rvalidport = 8'hFF;
    bus.out_ready  = 1'b1;
    hold_left      = 0;
    step();
    chk("mid_outread", 32'(bus.outread), 32'd1);
    tick();
    tick();
    tick();
    chk("mid_row3", 32'(bus.out_row), 32'd3);
    rst = 1'b1;
    step();
    chk("mid_rst_valid",   32'(bus.out_valid), 32'd0);
    chk("mid_rst_outread", 32'(bus.outread),   32'd0);
    chk("mid_rst_last",    32'(bus.out_last),  32'd0);
    chk("mid_rst_data",    bus.out_data,       32'd0);
    chk("mid_rst_row",     32'(bus.out_row),   32'd0);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      chk($sformatf("after_rst_c%0d_valid", c), 32'(bus.out_valid), 32'd0);
      chk($sformatf("after_rst_c%0d_outread", c), 32'(bus.outread), 32'd0);
    end

    // Three frames of 8, 3 and 1 rows from a fresh reset.
    v = '{8'hFF, 8'hFF, 32'h7000_0000, 0, 8, 3'd7};
    run_frame(v, 10);
    v = '{8'h07, 8'hFF, 32'h7100_0000, 0, 3, 3'd2};
    run_frame(v, 11);
    v = '{8'h10, 8'hFF, 32'h7200_0000, 0, 1, 3'd4};
    run_frame(v, 12);
`ifdef SA_DRAIN_STATS_EN
    chk("stats_frame_cnt", 32'(frame_cnt), 32'd3);
    chk("stats_word_cnt",  32'(word_cnt),  32'd12);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sa_result_drain.md
# sa_result_drain

Result drain unit for the systolic array core. It watches the core's per-row result bus and valid bits, and snapshots every valid row in one cycle. It acknowledges the capture to the core with a one-cycle `outread` pulse, then serialises the captured rows onto a single 32-bit valid/ready stream in ascending row order. It sits between the array core and the result writeback path, replacing the ad-hoc `outread` driving done by benches today.

## Interface
Parameters:
- `ROWS`, 8: number of array rows; also the width of `rvalidport`.
- `DW`, 32: result word width.

Ports:
- `clk`  in  1: clock; all logic on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `routport`  in  `ROWS` x `DW`: per-row results from the core.
- `rvalidport`  in  `ROWS`: per-row result-valid from the core. Bit i qualifies `routport[i]`.
- `outread`  out  1: one-cycle capture acknowledge to the core.
- `out_data`  out  `DW`: serialised result word.
- `out_row`  out  `$clog2(ROWS)`: row index of `out_data`.
- `out_last`  out  1: marks the final word of the current frame.
- `out_valid`  out  1: stream valid.
- `out_ready`  in  1: stream ready from downstream.

## Operation
- States:
  - IDLE: waiting for results.
  - DRAIN: emitting captured rows.
  - GAP: one-cycle cooldown.
- IDLE → DRAIN when `rvalidport != 0`. On that edge:
  - the snapshot register (`ROWS` x `DW`) is loaded from `routport`;
  - mask register ← `rvalidport`;
  - `outread` ← 1 for exactly one cycle.
- Rows whose `rvalidport` bit is 0 at capture are not emitted. Their `routport` value is ignored.
- DRAIN behaviour:
  - `out_valid` = 1.
  - `out_row` = lowest set mask bit; `out_data` = snapshot at that row.
  - `out_last` = 1 iff exactly one mask bit remains set.
- On a handshake (`out_valid && out_ready`), the current mask bit clears. If it was the last set bit, the state goes to GAP.
- GAP → IDLE unconditionally. `rvalidport` is ignored in GAP, so that stale valids from the core are never re-captured.
- While in DRAIN or GAP, `rvalidport` and `routport` changes have no effect. The snapshot is frozen.
- The core is expected to drop `rvalidport` no later than the cycle after `outread`.
- `out_data`, `out_row` and `out_last` hold stable while `out_valid && !out_ready`.
- Output values are a pure copy of the snapshot; no arithmetic or truncation is applied to `out_data`.

## Timing
- Reset (any state, including mid-drain):
  - state IDLE; mask 0; snapshot 0;
  - `outread`, `out_valid`, `out_last`, `out_data` and `out_row` all 0;
  - an abandoned frame is discarded; no `outread` is issued for it.
- Capture latency: `rvalidport` seen in IDLE at cycle T → `outread` = 1 and `out_valid` = 1 in cycle T+1.
- Throughput in DRAIN: one word per cycle with `out_ready` held high. A frame of k valid rows occupies DRAIN for k cycles minimum.
- Frame-to-frame: last handshake at cycle T → GAP at T+1 → IDLE at T+2. The earliest next `outread` is at T+3.
- `out_ready` may be asserted before `out_valid`. The first word is accepted in the first cycle where both are high.
- `outread` is never high in DRAIN after the first cycle, nor in GAP.

## Configuration
- Macro: `SA_DRAIN_STATS_EN`.
- Defined:
  - adds output `frame_cnt` [15:0], counting completed frames (incremented on the last handshake), reset 0, wraps 0xFFFF → 0;
  - adds output `word_cnt` [15:0], counting all handshakes, reset 0, wraps.
- Undefined: neither port nor counter exists; the rest of the behaviour is identical.

## Test plan
- Full frame: reset, then `rvalidport` = 0xFF with `routport[i]` = 100+i, and `out_ready` = 1. Required response:
  - one `outread` pulse;
  - 8 consecutive words 100..107 with `out_row` 0..7;
  - `out_last` only on row 7;
  - `out_valid` drops 1 cycle after row 7.
- Sparse mask: `rvalidport` = 0b10100100 → exactly 3 words, rows 2, 5, 7, with `out_last` on row 7. Words for other rows are never emitted.
- Backpressure: full frame with `out_ready` toggling 1,0,0,1,… → words stay stable during stalls. The order and values match the full-frame case, and no word is duplicated or dropped.
- Stale valid: hold `rvalidport` = 0xFF for 2 cycles after `outread` → only one frame is captured (GAP/DRAIN ignore it). A new frame begins only after valid re-asserts in IDLE.
- Reset mid-drain: assert `rst` after 3 of 8 words have been accepted → next cycle all outputs are 0. After release, no words are emitted until a new `rvalidport`.
- With `SA_DRAIN_STATS_EN`: 3 frames of 8, 3 and 1 rows → `frame_cnt` = 3 and `word_cnt` = 12.
